// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache between the IF-stage PC and a
// multicycle main memory. A hit returns the instruction combinationally. A miss
// stalls the fetch while a two-state fill FSM reads the whole line, one word per
// req/valid handshake.
// Optional build macro: ICACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module icache_dm #(
   parameter int unsigned INDEX_BITS  = 5,
   parameter int unsigned OFFSET_BITS = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   input  logic        inval,
   output logic [15:0] if_instr,
   output logic        if_stall,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic [15:0] mem_data,
   input  logic        mem_valid
`ifdef ICACHE_STATS_EN
   ,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
`endif
);

   localparam int unsigned SETS     = 1 << INDEX_BITS;
   localparam int unsigned WORDS    = 1 << OFFSET_BITS;
   localparam int unsigned TAG_LSB  = OFFSET_BITS + INDEX_BITS + 1;
   localparam int unsigned TAG_BITS = 16 - TAG_LSB;
   // Block number: the address with the byte and word-offset bits dropped.
   localparam int unsigned BLK_BITS = 16 - OFFSET_BITS - 1;

   typedef enum logic {StIdle, StFill} state_e;

   // Storage
   logic [SETS-1:0]     r_valid;
   logic [TAG_BITS-1:0] r_tag  [SETS];
   logic [15:0]         r_data [SETS][WORDS];

   // Fill engine state
   state_e                 r_state;
   state_e                 w_state_d;
   logic [BLK_BITS-1:0]    r_fill_blk;
   logic [OFFSET_BITS-1:0] r_fill_cnt;
   logic                   r_inval_seen;
   logic                   r_mem_req;
   logic                   w_mem_req_d;
   logic [15:0]            r_mem_addr;
   logic [15:0]            w_mem_addr_d;

   // Address decode
   logic [OFFSET_BITS-1:0] w_offset;
   logic [INDEX_BITS-1:0]  w_index;
   logic [TAG_BITS-1:0]    w_tag;
   logic [BLK_BITS-1:0]    w_blk;
   logic [INDEX_BITS-1:0]  w_fill_idx;
   logic [TAG_BITS-1:0]    w_fill_tag;
   logic [OFFSET_BITS-1:0] w_cnt_inc;

   logic w_hit;
   logic w_start;
   logic w_ack;
   logic w_last;
   logic w_unused_bits;

   assign w_offset   = if_addr[OFFSET_BITS:1];
   assign w_index    = if_addr[TAG_LSB-1:OFFSET_BITS+1];
   assign w_tag      = if_addr[15:TAG_LSB];
   assign w_blk      = if_addr[15:OFFSET_BITS+1];
   assign w_fill_idx = r_fill_blk[INDEX_BITS-1:0];
   assign w_fill_tag = r_fill_blk[BLK_BITS-1:INDEX_BITS];
   assign w_cnt_inc  = r_fill_cnt + OFFSET_BITS'(1);

   // Instructions are halfword aligned; the byte bit carries no information.
   assign w_unused_bits = if_addr[0];

   // Hit detection and instruction read, both combinational
   always_comb begin
      w_hit    = if_req & r_valid[w_index] & (r_tag[w_index] == w_tag);
      if_instr = w_hit ? r_data[w_index][w_offset] : 16'h0000;
      if_stall = if_req & ~w_hit;
   end

   assign w_start  = (r_state == StIdle) & if_req & ~w_hit;
   // A stray mem_valid with no outstanding request is not an acknowledge.
   assign w_ack    = (r_state == StFill) & r_mem_req & mem_valid;
   assign w_last   = w_ack & (&r_fill_cnt);
   assign mem_req  = r_mem_req;
   assign mem_addr = r_mem_addr;

   // Fill FSM next state and next registered memory request
   always_comb begin
      w_state_d    = r_state;
      w_mem_req_d  = r_mem_req;
      w_mem_addr_d = r_mem_addr;
      unique case (r_state)
         StIdle: begin
            if (w_start) begin
               w_state_d    = StFill;
               w_mem_req_d  = 1'b1;
               w_mem_addr_d = {w_blk, {(OFFSET_BITS + 1){1'b0}}};
            end
         end
         StFill: begin
            if (w_last) begin
               // mem_addr keeps its last value while idle
               w_state_d   = StIdle;
               w_mem_req_d = 1'b0;
            end else if (w_ack) begin
               // Offset bits of the block base are zero, so this never carries out of the line.
               w_mem_addr_d = {r_fill_blk, w_cnt_inc, 1'b0};
            end
         end
         default: begin
            w_state_d   = StIdle;
            w_mem_req_d = 1'b0;
         end
      endcase
   end

   // Fill FSM state, fill pointer and registered memory request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= StIdle;
         r_fill_blk   <= '0;
         r_fill_cnt   <= '0;
         r_inval_seen <= 1'b0;
         r_mem_req    <= 1'b0;
         r_mem_addr   <= 16'h0000;
      end else begin
         r_state    <= w_state_d;
         r_mem_req  <= w_mem_req_d;
         r_mem_addr <= w_mem_addr_d;
         if (w_start) begin
            r_fill_blk   <= w_blk;
            r_fill_cnt   <= '0;
            r_inval_seen <= 1'b0;
         end else if (w_ack) begin
            r_fill_cnt <= w_cnt_inc;
         end
         // Any invalidate seen mid-fill makes the completed line stale.
         if (w_last) begin
            r_inval_seen <= 1'b0;
         end else if ((r_state == StFill) && inval) begin
            r_inval_seen <= 1'b1;
         end
      end
   end

   // Valid bits and tags: invalidate, drop the victim at fill start, install at fill end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         for (int unsigned i = 0; i < SETS; i++) begin
            r_tag[i] <= '0;
         end
      end else begin
         if (w_last) begin
            r_tag[w_fill_idx] <= w_fill_tag;
         end
         if (inval) begin
            r_valid <= '0;
         end else begin
            // The victim line is being overwritten, so it must not hit mid-fill.
            if (w_start) begin
               r_valid[w_index] <= 1'b0;
            end
            if (w_last && !r_inval_seen) begin
               r_valid[w_fill_idx] <= 1'b1;
            end
         end
      end
   end

   // Line data array, written one word per acknowledged memory read
   always_ff @(posedge clk) begin
      if (w_ack) begin
         r_data[w_fill_idx][r_fill_cnt] <= mem_data;
      end
   end

`ifdef ICACHE_STATS_EN
   logic [15:0] r_hit_count;
   logic [15:0] r_miss_count;

   // Saturating hit and miss event counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hit_count  <= 16'h0000;
         r_miss_count <= 16'h0000;
      end else begin
         if (w_hit && (r_hit_count != 16'hFFFF)) begin
            r_hit_count <= r_hit_count + 16'd1;
         end
         if (w_start && (r_miss_count != 16'hFFFF)) begin
            r_miss_count <= r_miss_count + 16'd1;
         end
      end
   end

   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed self-checking bench for icache_dm. A small memory model answers each
// request after a programmable latency with data 0x1000 + (address >> 1).
module tb_icache_dm;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [15:0] if_addr;
   logic        inval;
   logic [15:0] if_instr;
   logic        if_stall;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic [15:0] mem_data;
   logic        mem_valid;
`ifdef ICACHE_STATS_EN
   logic [15:0] hit_count;
   logic [15:0] miss_count;
`endif

   int checks = 0;
   int errors = 0;

   // Memory model controls
   int   mem_lat = 0;
   int   r_wait;
   logic stray_valid = 1'b0;

   logic [15:0] seq [8];

   icache_dm u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .inval     (inval),
      .if_instr  (if_instr),
      .if_stall  (if_stall),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_valid (mem_valid)
`ifdef ICACHE_STATS_EN
      ,
      .hit_count (hit_count),
      .miss_count(miss_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: ack mem_lat cycles after the request first appears
   always @(posedge clk) begin
      if (!mem_req || mem_valid) r_wait <= 0;
      else                       r_wait <= r_wait + 1;
   end

   always_comb begin
      mem_valid = (mem_req && (r_wait == mem_lat)) || stray_valid;
      mem_data  = 16'h1000 + {1'b0, mem_addr[15:1]};
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a fetch from just after a rising edge. Ends on a hit, when a fill
   // finishes without producing a hit, after stop_acks acks, or at the cycle
   // budget. Leaves if_req low and returns just after a rising edge.
   task automatic fetch(input logic [15:0] addr, input int inval_at, input int stop_acks,
                        output int stalls, output int acks, output int moved,
                        output logic [15:0] instr, output logic end_stall,
                        output logic end_req);
      logic        have_prev;
      logic [15:0] prev_addr;
      if_req    = 1'b1;
      if_addr   = addr;
      stalls    = 0;
      acks      = 0;
      moved     = 0;
      have_prev = 1'b0;
      prev_addr = 16'h0000;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         instr     = if_instr;
         end_stall = if_stall;
         end_req   = mem_req;
         if (!if_stall) break;
         if (acks == 8 && !mem_req) break;
         stalls++;
         if (mem_req && have_prev && (mem_addr !== prev_addr)) moved++;
         if (mem_req && mem_valid) begin
            if (acks < 8) seq[acks] = mem_addr;
            acks++;
            have_prev = 1'b0;
         end else if (mem_req) begin
            have_prev = 1'b1;
            prev_addr = mem_addr;
         end
         if (acks == stop_acks) break;
         @(posedge clk);
         #1;
         inval = (acks == inval_at);
      end
      if_req = 1'b0;
      inval  = 1'b0;
      @(posedge clk);
      #1;
   endtask

   int          st;
   int          ak;
   int          mv;
   logic [15:0] ins;
   logic        est;
   logic        erq;

   initial begin
      rst_n   = 1'b0;
      if_req  = 1'b0;
      if_addr = 16'h0000;
      inval   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_stall", {15'h0, if_stall}, 16'h0000);
      chk("rst_req",   {15'h0, mem_req},  16'h0000);
      chk("rst_addr",  mem_addr,          16'h0000);
      chk("rst_instr", if_instr,          16'h0000);
      @(posedge clk);
      #1;

      // Cold miss at 0x0000, same-cycle memory: 9 stall cycles, addresses 0x0..0xE
      fetch(16'h0000, -1, -1, st, ak, mv, ins, est, erq);
      chk("cold_stalls", 16'(st), 16'd9);
      chk("cold_acks",   16'(ak), 16'd8);
      for (int i = 0; i < 8; i++) chk($sformatf("cold_addr%0d", i), seq[i], 16'(2 * i));
      chk("cold_instr",  ins, 16'h1000);

      // Hit on word 5 of the filled line
      fetch(16'h000A, -1, -1, st, ak, mv, ins, est, erq);
      chk("hitA_stalls", 16'(st), 16'd0);
      chk("hitA_instr",  ins, 16'h1005);
      chk("hitA_req",    {15'h0, erq}, 16'h0000);

      // Conflict: 0x0200 shares index 0 with a different tag
      fetch(16'h0200, -1, -1, st, ak, mv, ins, est, erq);
      chk("conf_stalls", 16'(st), 16'd9);
      chk("conf_first",  seq[0], 16'h0200);
      chk("conf_last",   seq[7], 16'h020E);
      chk("conf_instr",  ins, 16'h1100);
      fetch(16'h0000, -1, -1, st, ak, mv, ins, est, erq);
      chk("evict_stalls", 16'(st), 16'd9);
      chk("evict_instr",  ins, 16'h1000);

      // Slow memory: each word acked 3 cycles after its request
      mem_lat = 3;
      fetch(16'h0040, -1, -1, st, ak, mv, ins, est, erq);
      chk("slow_stalls", 16'(st), 16'd33);
      chk("slow_acks",   16'(ak), 16'd8);
      chk("slow_moved",  16'(mv), 16'd0);
      chk("slow_last",   seq[7], 16'h004E);
      chk("slow_instr",  ins, 16'h1020);
      mem_lat = 0;

      // inval during fill word 4: fill completes but the line stays invalid
      fetch(16'h0080, 4, -1, st, ak, mv, ins, est, erq);
      chk("inv_acks",   16'(ak), 16'd8);
      chk("inv_stalls", 16'(st), 16'd9);
      chk("inv_miss",   {15'h0, est}, 16'h0001);
      fetch(16'h0080, -1, -1, st, ak, mv, ins, est, erq);
      chk("inv_refill", 16'(st), 16'd9);
      chk("inv_instr",  ins, 16'h1040);

      // inval on the completion edge itself
      fetch(16'h0100, 7, -1, st, ak, mv, ins, est, erq);
      chk("invlast_acks", 16'(ak), 16'd8);
      chk("invlast_miss", {15'h0, est}, 16'h0001);
      fetch(16'h0100, -1, -1, st, ak, mv, ins, est, erq);
      chk("invlast_refill", 16'(st), 16'd9);
      chk("invlast_instr",  ins, 16'h1080);

      // Stray mem_valid while idle is ignored
      stray_valid = 1'b1;
      @(posedge clk);
      #1;
      stray_valid = 1'b0;
      @(negedge clk);
      chk("stray_req",  {15'h0, mem_req}, 16'h0000);
      chk("stray_addr", mem_addr, 16'h010E);
      @(posedge clk);
      #1;
      fetch(16'h0100, -1, -1, st, ak, mv, ins, est, erq);
      chk("stray_hit",   16'(st), 16'd0);
      chk("stray_instr", ins, 16'h1080);

      // Asynchronous reset at fill word 5
      fetch(16'h0000, -1, 5, st, ak, mv, ins, est, erq);
      chk("rstfill_req_pre",  {15'h0, mem_req}, 16'h0001);
      chk("rstfill_addr_pre", mem_addr, 16'h000A);
      rst_n = 1'b0;
      #1;
      chk("rstfill_req",  {15'h0, mem_req}, 16'h0000);
      chk("rstfill_addr", mem_addr, 16'h0000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      fetch(16'h0100, -1, -1, st, ak, mv, ins, est, erq);
      chk("post_rst_stalls", 16'(st), 16'd9);
      chk("post_rst_instr",  ins, 16'h1080);
      fetch(16'h0080, -1, -1, st, ak, mv, ins, est, erq);
      chk("post_rst_stalls2", 16'(st), 16'd9);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
